regfile_bist: RTL and testbench
===============================

Name: regfile_bist

Overview:
- Built-in self-test initiator for `register_file`. It drives the register file's read and write ports (raddr_rs1, raddr_rs2, waddr_rd, wdata_rd, we) and checks the read data that comes back.
- It runs three march patterns over every register. It checks that x0 stays zero and checks both read ports.
- It reports pass/fail with a capture of the first failure.
- It sits beside the register file behind a test mux; the core datapath is disconnected while busy.

Parameters:
- NREGS, 32, number of registers (power of 2)
- AW, 5, address width (log2 NREGS)
- DW, 32, data width (DW >= 2*AW)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a test run; sampled only in IDLE or DONE
- busy  output  1  test in progress
- done  output  1  test finished; held until the next start
- pass  output  1  valid when done; 1 = no mismatch
- fail_pat  output  2  pattern index of the first mismatch
- fail_port  output  1  0 = rs1, 1 = rs2
- fail_addr  output  AW  register address of the first mismatch
- fail_data  output  DW  data read at the first mismatch
- raddr_rs1  output  AW  to register file
- raddr_rs2  output  AW  to register file
- waddr_rd  output  AW  to register file
- wdata_rd  output  DW  to register file
- we  output  1  to register file write enable
- rdata_rs1  input  DW  from register file
- rdata_rs2  input  DW  from register file

Behaviour:
- Register file contract:
  - writes occur at the rising clk edge when we=1;
  - reads are combinational from the raddr inputs;
  - x0 always reads 0.
- Reset (async, rst_n=0):
  - state goes to IDLE;
  - busy, done, pass, we, all addresses, wdata_rd, fail_* go to 0 immediately.
- Patterns, for p in 0..2:
  - P0 = all 0x5 nibbles (0x55555555);
  - P1 = all 0xA nibbles (0xAAAAAAAA);
  - P2(a) = {a, (DW-2*AW) zeros, a}, an address-unique value.
  - Expected read value E(p,a) is 0 for a=0, else the pattern value.
- States: IDLE, WRITE, READ, DONE. Counters: pat (2 bits) and a (AW bits).
- IDLE:
  - we=0;
  - start=1 at an edge → WRITE with pat=0, a=0, busy=1 from the next cycle.
- WRITE, one cycle per address, a=0..NREGS-1:
  - we=1, waddr_rd=a;
  - wdata_rd = ~P0 (0xAAAAAAAA) for a=0, otherwise the pattern value.
  - At a=NREGS-1 → READ with a=0.
- READ, one cycle per address, a=0..NREGS-1:
  - we=0, raddr_rs1=a, raddr_rs2=(NREGS-a) mod NREGS;
  - compare rdata_rs1 vs E(p,raddr_rs1) and rdata_rs2 vs E(p,raddr_rs2) in the same cycle.
- On the first mismatch, at that edge:
  - capture fail_pat, fail_addr, fail_data and fail_port; rs1 has priority if both ports mismatch;
  - → DONE with pass=0.
- End of READ with no mismatch:
  - a=NREGS-1 with pat<2 → WRITE, pat+1;
  - a=NREGS-1 with pat=2 → DONE with pass=1.
- Full-pass duration: busy=1 for exactly 6*NREGS cycles (192 at defaults); done=1 and busy=0 the cycle after.
- DONE:
  - done and pass stay stable, we=0, addresses 0;
  - start=1 → WRITE with pat=0, clearing done, pass and fail_* at that edge.
- start is ignored while busy. start held high in DONE restarts immediately.
- Counters wrap only through the explicit transitions above; a never exceeds NREGS-1.
- Reset mid-run aborts with no write in flight: we drops asynchronously. Register file contents are unspecified after an abort.
- In all non-WRITE states, wdata_rd=0 and waddr_rd=0.

Test Plan:
- Good register file (real `register_file`): reset, 1-cycle start pulse → busy high 192 cycles; then done=1, pass=1, fail_addr=0, we never asserted outside WRITE.
- Behavioural regfile model, x7 bit3 stuck-at-0:
  - → done with pass=0, fail_pat=1, fail_addr=7, fail_port=0, fail_data=0xAAAAAAA2;
  - done rises the cycle after the read of a=7 in pattern 1 (cycle 64+32+7+1 after start).
- Model where x0 is writable → fail_pat=0, fail_addr=0, fail_port=0, fail_data=0xAAAAAAAA, detected on the first READ cycle (cycle 33).
- Model ignoring waddr bit4 (x17 aliases x1):
  - patterns 0 and 1 pass;
  - pattern 2 gives fail_addr=1, fail_port=0, fail_data=0x88000011 ({17,22'b0,17}).
- Drive rst_n=0 at cycle 40 of a run → busy, we, done, pass go to 0 without waiting for a clock edge; release, start again → full pass in 192 cycles.
- Start pulses during busy are ignored (run length unchanged).
  - start in DONE → done and pass clear at the next edge and a new 192-cycle run begins.
  - Second run after a failed run on a good model → pass=1 and fail_* all 0.

Source files
------------

// File: rtl/regfile_bist.sv
// March-pattern self-test initiator for a two-read/one-write register file.
// Three patterns are written to every register, then read back on both ports; the first mismatch is captured.
module regfile_bist #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [1:0]    fail_pat,
  output logic          fail_port,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [AW-1:0] raddr_rs1,
  output logic [AW-1:0] raddr_rs2,
  output logic [AW-1:0] waddr_rd,
  output logic [DW-1:0] wdata_rd,
  output logic          we,
  input  logic [DW-1:0] rdata_rs1,
  input  logic [DW-1:0] rdata_rs2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_A = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [1:0]    pat_q, pat_d;
  logic [AW-1:0] a_q, a_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [1:0]    fail_pat_q, fail_pat_d;
  logic          fail_port_q, fail_port_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [DW-1:0] fail_data_q, fail_data_d;
  logic [AW-1:0] raddr_rs1_q, raddr_rs1_d, raddr_rs2_q, raddr_rs2_d, waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          mism1_s, mism2_s;

  // Alternating-bit word: bit0=1 gives the 0x5 nibble pattern, bit0=0 gives 0xA.
  function automatic logic [DW-1:0] alt_word(input logic odd_ones);
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i++) begin
      v[i] = (i[0] == 1'b0) ? odd_ones : ~odd_ones;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] pat_val(input logic [1:0] p, input logic [AW-1:0] addr);
    logic [DW-1:0] v;
    case (p)
      2'd0: v = alt_word(1'b1);
      2'd1: v = alt_word(1'b0);
      2'd2: begin
        v = '0;
        v[AW-1:0] = addr;
        v[DW-1 -: AW] = addr;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_val(input logic [1:0] p, input logic [AW-1:0] addr);
    return (addr == '0) ? '0 : pat_val(p, addr);
  endfunction

  assign mism1_s = (state_q == READ) && (rdata_rs1 != exp_val(pat_q, raddr_rs1_q));
  assign mism2_s = (state_q == READ) && (rdata_rs2 != exp_val(pat_q, raddr_rs2_q));

  // Next-state, counters, result capture and registered port decode.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    a_d         = a_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_pat_d  = fail_pat_q;
    fail_port_d = fail_port_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          pat_d   = 2'd0;
          a_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (a_q == LAST_A) begin
          state_d = READ;
          a_d     = '0;
        end else begin
          a_d = a_q + AW'(1);
        end
      end
      READ: begin
        if (mism1_s || mism2_s) begin
          // rs1 wins when both ports disagree in the same cycle
          state_d     = DONE;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_pat_d  = pat_q;
          fail_port_d = ~mism1_s;
          fail_addr_d = mism1_s ? raddr_rs1_q : raddr_rs2_q;
          fail_data_d = mism1_s ? rdata_rs1 : rdata_rs2;
        end else if (a_q == LAST_A) begin
          if (pat_q == 2'd2) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = WRITE;
            pat_d   = pat_q + 2'd1;
            a_d     = '0;
          end
        end else begin
          a_d = a_q + AW'(1);
        end
      end
      DONE: begin
        if (start) begin
          state_d     = WRITE;
          pat_d       = 2'd0;
          a_d         = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_pat_d  = 2'd0;
          fail_port_d = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d == WRITE) || (state_d == READ);
    we_d        = (state_d == WRITE);
    waddr_d     = (state_d == WRITE) ? a_d : '0;
    wdata_d     = '0;
    if (state_d == WRITE) begin
      wdata_d = (a_d == '0) ? alt_word(1'b0) : pat_val(pat_d, a_d);
    end else begin
      wdata_d = '0;
    end
    raddr_rs1_d = (state_d == READ) ? a_d : '0;
    raddr_rs2_d = (state_d == READ) ? (AW'(0) - a_d) : '0;
  end

  // State and output registers; reset clears everything at once so no write survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pat_q       <= 2'd0;
      a_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_pat_q  <= 2'd0;
      fail_port_q <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      raddr_rs1_q <= '0;
      raddr_rs2_q <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      a_q         <= a_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_pat_q  <= fail_pat_d;
      fail_port_q <= fail_port_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      raddr_rs1_q <= raddr_rs1_d;
      raddr_rs2_q <= raddr_rs2_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_pat  = fail_pat_q;
  assign fail_port = fail_port_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign raddr_rs1 = raddr_rs1_q;
  assign raddr_rs2 = raddr_rs2_q;
  assign waddr_rd  = waddr_q;
  assign wdata_rd  = wdata_q;
  assign we        = we_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: a behavioural register file with injectable faults, a table of runs,
// and a predictor that walks the march algorithm over an array to derive the expected outcome.
module tb_regfile_bist;
  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, fail_port, we;
  logic [1:0]  fail_pat;
  logic [4:0]  fail_addr, raddr_rs1, raddr_rs2, waddr_rd;
  logic [31:0] fail_data, wdata_rd, rdata_rs1, rdata_rs2;

  regfile_bist #(.NREGS(32), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_pat(fail_pat), .fail_port(fail_port), .fail_addr(fail_addr), .fail_data(fail_data),
    .raddr_rs1(raddr_rs1), .raddr_rs2(raddr_rs2), .waddr_rd(waddr_rd), .wdata_rd(wdata_rd),
    .we(we), .rdata_rs1(rdata_rs1), .rdata_rs2(rdata_rs2)
  );

  always #5 clk = ~clk;

  // fault modes: 0 good, 1 stuck bit on one register, 2 x0 writable, 3 waddr/raddr bit4 ignored
  int fmode = 0, freg = 0, fbit = 0, fval = 0;
  int checks = 0, errors = 0, we_bad = 0;
  logic [31:0] mem [N];

  function automatic int map_index(input int a);
    if (fmode == 2) return a;
    if (a == 0) return -1;
    if (fmode == 3) return a % 16;
    return a;
  endfunction

  function automatic logic [31:0] fix(input int a, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (fmode == 1 && a == freg) r[fbit] = (fval != 0);
    return r;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    int ri;
    ri = map_index(int'(a));
    if (ri < 0) return 32'h0;
    return fix(int'(a), mem[ri]);
  endfunction

  always @(posedge clk) begin
    if (we && map_index(int'(waddr_rd)) >= 0) mem[map_index(int'(waddr_rd))] <= wdata_rd;
  end
  assign rdata_rs1 = rd_model(raddr_rs1);
  assign rdata_rs2 = rd_model(raddr_rs2);

  always @(negedge clk) begin
    if (rst_n && we && !busy) we_bad <= we_bad + 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  typedef struct {
    int          mode, reg_n, bitn, val;
    bit          ign;
    bit          epass;
    int          epat, eport, eaddr;
    logic [31:0] edata;
    int          ecyc;
  } vec_t;

  function automatic logic [31:0] patv(input int p, input int a);
    if (p == 0) return 32'h5555_5555;
    if (p == 1) return 32'hAAAA_AAAA;
    return (32'(a) << 27) | 32'(a);
  endfunction

  // Walk the three patterns over an array with the current fault applied and report the first miscompare.
  task automatic predict(inout vec_t v);
    logic [31:0] pm [N];
    logic [31:0] got, want;
    int wi, ri, addr;
    for (int i = 0; i < N; i++) pm[i] = 32'h0;
    v.epass = 1'b1; v.epat = 0; v.eport = 0; v.eaddr = 0; v.edata = 32'h0; v.ecyc = 6 * N;
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < N; a++) begin
        wi = map_index(a);
        if (wi >= 0) pm[wi] = (a == 0) ? 32'hAAAA_AAAA : patv(p, a);
      end
      for (int a = 0; a < N; a++) begin
        for (int port = 0; port < 2; port++) begin
          addr = (port == 0) ? a : (N - a) % N;
          ri = map_index(addr);
          got = (ri < 0) ? 32'h0 : fix(addr, pm[ri]);
          want = (addr == 0) ? 32'h0 : patv(p, addr);
          if (got != want) begin
            v.epass = 1'b0; v.epat = p; v.eport = port; v.eaddr = addr; v.edata = got;
            v.ecyc = p * 2 * N + N + a + 1;
            return;
          end
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, bcnt, wcnt, exp_we;
    logic pass_seen;
    fmode = v.mode; freg = v.reg_n; fbit = v.bitn; fval = v.val;
    pulse_start();
    chk($sformatf("v%0d start_busy", idx), 64'(busy), 64'(1'b1));
    chk($sformatf("v%0d start_clears", idx),
        {57'h0, done, pass, fail_pat, fail_port, 2'b00}, 64'h0);
    chk($sformatf("v%0d start_fail_clr", idx), {27'h0, fail_addr, fail_data}, 64'h0);
    cyc = 0; bcnt = 0; wcnt = 0;
    while (!done && cyc < 400) begin
      if (busy) bcnt++;
      if (we) wcnt++;
      @(posedge clk);
      #1;
      cyc++;
      start = (v.ign && $urandom_range(0, 7) == 0) && !done;
    end
    start = 1'b0;
    exp_we = v.epass ? 3 * N : (v.epat + 1) * N;
    chk($sformatf("v%0d done_cycle", idx), 64'(cyc), 64'(v.ecyc));
    chk($sformatf("v%0d busy_cycles", idx), 64'(bcnt), 64'(v.ecyc));
    chk($sformatf("v%0d we_cycles", idx), 64'(wcnt), 64'(exp_we));
    chk($sformatf("v%0d busy_low", idx), 64'(busy), 64'(1'b0));
    chk($sformatf("v%0d pass", idx), 64'(pass), 64'(v.epass));
    chk($sformatf("v%0d fail_pat", idx), 64'(fail_pat), 64'(v.epat));
    chk($sformatf("v%0d fail_port", idx), 64'(fail_port), 64'(v.eport));
    chk($sformatf("v%0d fail_addr", idx), 64'(fail_addr), 64'(v.eaddr));
    chk($sformatf("v%0d fail_data", idx), 64'(fail_data), 64'(v.edata));
    chk($sformatf("v%0d done_ports_idle", idx),
        {32'h0, we, raddr_rs1, raddr_rs2, waddr_rd, 12'h0}, 64'h0);
    chk($sformatf("v%0d done_wdata", idx), 64'(wdata_rd), 64'h0);
    pass_seen = pass;
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d done_hold", idx), {62'h0, done, pass}, {62'h0, 1'b1, pass_seen});
  endtask

  vec_t vecs [13];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 32'h0;
    vecs[0] = '{0, 0, 0, 0, 1'b0, 1'b1, 0, 0, 0, 32'h0, 192};
    vecs[1] = '{1, 7, 3, 0, 1'b0, 1'b0, 1, 0, 7, 32'hAAAA_AAA2, 104};
    vecs[2] = '{2, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 32'hAAAA_AAAA, 33};
    vecs[3] = '{3, 0, 0, 0, 1'b0, 1'b0, 2, 0, 1, 32'h8800_0011, 162};
    vecs[4] = '{0, 0, 0, 0, 1'b1, 1'b1, 0, 0, 0, 32'h0, 192};
    for (int i = 5; i < 13; i++) begin
      vecs[i].mode  = ($urandom_range(0, 5) == 0) ? 0 : 1;
      vecs[i].reg_n = $urandom_range(1, N - 1);
      vecs[i].bitn  = $urandom_range(0, 31);
      vecs[i].val   = $urandom_range(0, 1);
      vecs[i].ign   = 1'($urandom_range(0, 1));
      fmode = vecs[i].mode; freg = vecs[i].reg_n; fbit = vecs[i].bitn; fval = vecs[i].val;
      predict(vecs[i]);
    end
    fmode = 0;

    #23;
    chk("reset_flags", {60'h0, busy, done, pass, we}, 64'h0);
    chk("reset_addrs", {49'h0, raddr_rs1, raddr_rs2, waddr_rd}, 64'h0);
    chk("reset_fail", {26'h0, fail_pat, fail_port, fail_addr, fail_data}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start", {62'h0, busy, we}, 64'h0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Abort mid-run: reset must clear outputs without a clock edge.
    fmode = 0;
    pulse_start();
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_async", {60'h0, busy, we, done, pass}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], 99);

    chk("we_outside_write", 64'(we_bad), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
